brisc_mem_arbiter: RTL and testbench
====================================

Name: brisc_mem_arbiter

Overview:
- Shares the single main-memory line port between the I-cache miss path and the D-cache miss/writeback path.
- Accepts one cache-line request at a time and round-robins on a tie.
- Sequences the memory handshake (issue, wait) and routes the returned line back to the owning cache.
- Sits between both caches and the memory model, one outstanding transaction.

Parameters:
- ADDR_W, ADDRESS_BITS (32), request address width.
- LINE_W, CACHE_LINE_LEN (128), line data width.
- OFFSET_BITS, $clog2(LINE_W/BYTE_LEN) (4), low address bits forced to 0 on the memory side.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ic_req_i  in  1  I-cache line-fill request, held until ic_gnt_o seen.
- ic_addr_i  in  ADDR_W  I-cache miss address.
- ic_gnt_o  out  1  one-cycle pulse: I-cache request accepted.
- ic_resp_valid_o  out  1  one-cycle pulse: ic_rdata_o valid.
- ic_rdata_o  out  LINE_W  returned line.
- dc_req_i  in  1  D-cache request, held until dc_gnt_o seen.
- dc_we_i  in  1  1 = writeback, 0 = fill.
- dc_addr_i  in  ADDR_W  D-cache address.
- dc_wdata_i  in  LINE_W  writeback line.
- dc_gnt_o  out  1  one-cycle accept pulse.
- dc_resp_valid_o  out  1  one-cycle pulse: fill data or write ack.
- dc_rdata_o  out  LINE_W  returned line; 0 for a write ack.
- mem_req_valid_o  out  1  request valid to memory.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_W  line-aligned address.
- mem_wdata_o  out  LINE_W  write line.
- mem_resp_valid_i  in  1  response pulse, one per accepted request.
- mem_rdata_i  in  LINE_W  read line.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Registered outputs: all outputs are registered.
- Reset values: all outputs 0; state=IDLE; last_owner=OWNER_IC, so the first tie goes to the D-cache.
- State IDLE:
  - No request: stay in IDLE.
  - Exactly one request: that requester wins.
  - Both requesting: winner is the requester other than last_owner.
  - On win: latch owner, we (0 for I-cache), addr with low OFFSET_BITS cleared, and wdata (0 for I-cache). Update last_owner, go to ISSUE.
  - Winner's gnt_o is high for exactly the first ISSUE cycle.
- State ISSUE:
  - mem_req_valid_o=1 with the latched we/addr/wdata, held stable until mem_req_ready_i=1.
  - On the ready cycle: go to WAIT. mem_req_valid_o drops the following cycle.
  - Requests are not sampled outside IDLE. A requester still holding req after gnt is not re-granted until the next IDLE.
- State WAIT:
  - On mem_resp_valid_i: capture mem_rdata_i (or 0 if we=1) into the owner's rdata_o, and pulse the owner's resp_valid_o the next cycle. Go to IDLE.
  - rdata_o holds its value until that port's next response.
- Latency:
  - Request to gnt: 1 cycle.
  - Best case request to resp_valid: 4 cycles, with ready and response each one cycle after issue.
  - Back-to-back: a new grant can coincide with the previous resp_valid pulse.
- Out-of-protocol inputs: mem_resp_valid_i in IDLE or ISSUE is ignored. mem_req_ready_i outside ISSUE is ignored.
- Starvation: with both requesters continuously active, grants alternate DC, IC, DC, ...
- Reset mid-transaction: immediate return to IDLE with outputs 0. The outstanding memory transaction is abandoned and its late response is ignored in IDLE.

Decomposition:
- Add to brisc_pkg:
  - mem_owner_e {OWNER_IC=1'b0, OWNER_DC=1'b1}.
  - arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT} (2 bits).
  - LINE_OFFSET_BITS constant.
- One sub-module, brisc_rr_pick2: combinational two-way round-robin pick from (req0, req1, last_owner), producing a valid and winner.
- The FSM and datapath registers stay in brisc_mem_arbiter.

Test Plan:
- Reset, then ic_req with addr 0x0000_1004; memory ready next cycle, response 0xAAAA..AA after 2 cycles -> ic_gnt pulse, mem_addr=0x0000_1000, mem_we=0, ic_resp_valid one pulse with 0xAAAA..AA; dc outputs stay 0.
- ic_req and dc_req asserted in the same cycle after reset -> DC granted first; after its response IC is granted; no cycle has both gnts high.
- dc writeback: dc_we=1, addr 0x2010, wdata 0x1234..; mem_req_ready held low 5 cycles -> mem_req_valid high 6 cycles with stable addr/wdata; dc_resp_valid pulse with dc_rdata=0.
- Both requests held continuously for 6 transactions -> grant order DC, IC, DC, IC, DC, IC.
- Reset asserted in WAIT, then a mem_resp_valid pulse after reset release -> all outputs 0 immediately, stray response produces no resp_valid, and the next request is served normally.
- Spurious mem_resp_valid in IDLE and mem_req_ready in IDLE -> no state change, no output pulse.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared types and constants for the brisc memory subsystem.
// Line geometry, memory-port ownership and arbiter state encoding.
package brisc_pkg;

  localparam int ADDRESS_BITS     = 32;
  localparam int CACHE_LINE_LEN   = 128;
  localparam int BYTE_LEN         = 8;
  localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } mem_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/brisc_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
// Purely combinational, no backpressure of its own.
module brisc_rr_pick2
  import brisc_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  mem_owner_e last_owner,
  output logic       valid,
  output mem_owner_e winner
);

  // req0 is the I-cache side, req1 the D-cache side.
  always_comb begin
    valid  = req0 | req1;
    winner = OWNER_IC;
    if (req0 && req1) begin
      winner = (last_owner == OWNER_IC) ? OWNER_DC : OWNER_IC;
    end else if (req1) begin
      winner = OWNER_DC;
    end
  end

endmodule

// File: rtl/brisc_mem_arbiter.sv
// Shares the memory line port between I-cache fills and D-cache fills/writebacks, one transaction at a time.
// Grant 1 cycle after request; holds the memory request until ready; resp_valid one cycle after the line is captured.
module brisc_mem_arbiter
  import brisc_pkg::*;
#(
  parameter int ADDR_W      = ADDRESS_BITS,
  parameter int LINE_W      = CACHE_LINE_LEN,
  parameter int OFFSET_BITS = $clog2(LINE_W / BYTE_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_resp_valid_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_resp_valid_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [LINE_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1);

  arb_state_e        state;
  mem_owner_e        owner;
  mem_owner_e        last_owner;
  mem_owner_e        pick_winner;
  logic              pick_valid;
  logic              ic_resp_pend;
  logic              dc_resp_pend;
  logic [LINE_W-1:0] resp_line;

  brisc_rr_pick2 u_pick (
    .req0       (ic_req_i),
    .req1       (dc_req_i),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // A writeback is acknowledged with an all-zero line.
  assign resp_line = mem_we_o ? '0 : mem_rdata_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ARB_IDLE;
      owner           <= OWNER_IC;
      last_owner      <= OWNER_IC;
      ic_gnt_o        <= 1'b0;
      dc_gnt_o        <= 1'b0;
      ic_resp_valid_o <= 1'b0;
      dc_resp_valid_o <= 1'b0;
      ic_resp_pend    <= 1'b0;
      dc_resp_pend    <= 1'b0;
      ic_rdata_o      <= '0;
      dc_rdata_o      <= '0;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
    end else begin
      ic_gnt_o        <= 1'b0;
      dc_gnt_o        <= 1'b0;
      // The response pulse trails the line capture so a new grant can overlap it.
      ic_resp_valid_o <= ic_resp_pend;
      dc_resp_valid_o <= dc_resp_pend;
      ic_resp_pend    <= 1'b0;
      dc_resp_pend    <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner           <= pick_winner;
            last_owner      <= pick_winner;
            mem_req_valid_o <= 1'b1;
            state           <= ARB_ISSUE;
            if (pick_winner == OWNER_DC) begin
              dc_gnt_o    <= 1'b1;
              mem_we_o    <= dc_we_i;
              mem_addr_o  <= dc_addr_i & ~OFFSET_MASK;
              mem_wdata_o <= dc_wdata_i;
            end else begin
              ic_gnt_o    <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= ic_addr_i & ~OFFSET_MASK;
              mem_wdata_o <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_resp_valid_i) begin
            state <= ARB_IDLE;
            if (owner == OWNER_DC) begin
              dc_rdata_o   <= resp_line;
              dc_resp_pend <= 1'b1;
            end else begin
              ic_rdata_o   <= resp_line;
              ic_resp_pend <= 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brisc_mem_arbiter.sv
// Bench for brisc_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_brisc_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, ic_gnt, ic_resp_valid;
  logic [AW-1:0] ic_addr;
  logic [LW-1:0] ic_rdata;
  logic          dc_req, dc_we, dc_gnt, dc_resp_valid;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata, dc_rdata;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  brisc_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .ic_req_i         (ic_req),
    .ic_addr_i        (ic_addr),
    .ic_gnt_o         (ic_gnt),
    .ic_resp_valid_o  (ic_resp_valid),
    .ic_rdata_o       (ic_rdata),
    .dc_req_i         (dc_req),
    .dc_we_i          (dc_we),
    .dc_addr_i        (dc_addr),
    .dc_wdata_i       (dc_wdata),
    .dc_gnt_o         (dc_gnt),
    .dc_resp_valid_o  (dc_resp_valid),
    .dc_rdata_o       (dc_rdata),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_rdata_i      (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding line transfer, described by its fields and progress.
  bit            m_busy, m_accepted, m_last_dc, m_t_dc, m_t_we, m_pend_ic, m_pend_dc;
  logic [AW-1:0] m_t_addr;
  logic [LW-1:0] m_t_wdata;
  bit            e_ic_gnt, e_dc_gnt, e_ic_rv, e_dc_rv;
  logic [LW-1:0] e_ic_rdata, e_dc_rdata;

  task automatic model_reset();
    m_busy = 0; m_accepted = 0; m_last_dc = 0; m_t_dc = 0; m_t_we = 0;
    m_pend_ic = 0; m_pend_dc = 0; m_t_addr = '0; m_t_wdata = '0;
    e_ic_gnt = 0; e_dc_gnt = 0; e_ic_rv = 0; e_dc_rv = 0;
    e_ic_rdata = '0; e_dc_rdata = '0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    e_ic_rv = m_pend_ic; e_dc_rv = m_pend_dc;
    m_pend_ic = 0; m_pend_dc = 0;
    e_ic_gnt = 0; e_dc_gnt = 0;
    if (!m_busy) begin
      if (ic_req || dc_req) begin
        m_t_dc = dc_req && (!ic_req || !m_last_dc);
        m_t_we = m_t_dc ? dc_we : 1'b0;
        m_t_addr = (m_t_dc ? dc_addr : ic_addr) & ~32'hF;
        m_t_wdata = m_t_dc ? dc_wdata : '0;
        if (m_t_dc) e_dc_gnt = 1; else e_ic_gnt = 1;
        m_last_dc = m_t_dc;
        m_busy = 1;
        m_accepted = 0;
      end
    end else if (!m_accepted) begin
      if (mem_req_ready) m_accepted = 1;
    end else if (mem_resp_valid) begin
      if (m_t_dc) begin
        e_dc_rdata = m_t_we ? '0 : mem_rdata;
        m_pend_dc = 1;
      end else begin
        e_ic_rdata = mem_rdata;
        m_pend_ic = 1;
      end
      m_busy = 0;
    end
  endtask

  task automatic compare();
    check("ic_gnt", ic_gnt, e_ic_gnt);
    check("dc_gnt", dc_gnt, e_dc_gnt);
    check("mem_req_valid", mem_req_valid, m_busy && !m_accepted);
    if (m_busy && !m_accepted) begin
      check("mem_we", mem_we, m_t_we);
      check("mem_addr", mem_addr, m_t_addr);
      check("mem_wdata", mem_wdata, m_t_wdata);
    end
    check("ic_resp_valid", ic_resp_valid, e_ic_rv);
    check("dc_resp_valid", dc_resp_valid, e_dc_rv);
    check("ic_rdata", ic_rdata, e_ic_rdata);
    check("dc_rdata", dc_rdata, e_dc_rdata);
  endtask

  // Observations for the directed scenarios.
  int            n_ic_gnt, n_dc_gnt, n_ic_rv, n_dc_rv, n_both_gnt, n_valid, n_unstable;
  int            n_dc_nonzero, n_rv_with_gnt;
  logic [AW-1:0] obs_addr;
  logic [LW-1:0] obs_wdata;
  logic          obs_we;
  int            gnt_order[$];

  task automatic clear_obs();
    n_ic_gnt = 0; n_dc_gnt = 0; n_ic_rv = 0; n_dc_rv = 0; n_both_gnt = 0;
    n_valid = 0; n_unstable = 0; n_dc_nonzero = 0; n_rv_with_gnt = 0;
    obs_addr = '0; obs_wdata = '0; obs_we = 0;
    gnt_order.delete();
  endtask

  task automatic observe();
    if (ic_gnt) begin n_ic_gnt++; gnt_order.push_back(0); end
    if (dc_gnt) begin n_dc_gnt++; gnt_order.push_back(1); end
    if (ic_gnt && dc_gnt) n_both_gnt++;
    if (ic_resp_valid) n_ic_rv++;
    if (dc_resp_valid) n_dc_rv++;
    if ((ic_gnt || dc_gnt) && (ic_resp_valid || dc_resp_valid)) n_rv_with_gnt++;
    if (dc_gnt || dc_resp_valid || dc_rdata != '0) n_dc_nonzero++;
    if (mem_req_valid) begin
      n_valid++;
      if (n_valid == 1) begin
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
      end else if (mem_addr !== obs_addr || mem_wdata !== obs_wdata) begin
        n_unstable++;
      end
    end
  endtask

  // Environment: requesters (0 off, 1 one-shot, 2 continuous, 3 random) and a memory responder.
  int            ic_mode, dc_mode;
  int            rdy_delay_cfg, resp_delay_cfg, rdy_wait, resp_cnt;
  bit            spur, mem_out, resp_data_rand;
  logic [LW-1:0] resp_data_cfg;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_req();
    if (ic_req && ic_gnt) begin
      if (ic_mode != 2) ic_req = 0;
      if (ic_mode == 1) ic_mode = 0;
      if (ic_mode == 2) ic_addr = $urandom;
    end else if (!ic_req && ic_mode == 3 && $urandom_range(0, 2) == 0) begin
      ic_req = 1; ic_addr = $urandom;
    end
    if (dc_req && dc_gnt) begin
      if (dc_mode != 2) dc_req = 0;
      if (dc_mode == 1) dc_mode = 0;
      if (dc_mode == 2) begin dc_addr = $urandom; dc_we = $urandom_range(0, 1); dc_wdata = rand_line(); end
    end else if (!dc_req && dc_mode == 3 && $urandom_range(0, 2) == 0) begin
      dc_req = 1; dc_addr = $urandom; dc_we = $urandom_range(0, 1); dc_wdata = rand_line();
    end
  endtask

  task automatic drive_mem();
    mem_resp_valid = 0;
    mem_req_ready = 0;
    if (mem_out) begin
      if (resp_cnt == 0) begin
        mem_resp_valid = 1;
        mem_rdata = resp_data_rand ? rand_line() : resp_data_cfg;
        mem_out = 0;
      end else begin
        resp_cnt--;
      end
    end else if (spur && $urandom_range(0, 5) == 0) begin
      mem_resp_valid = 1;
      mem_rdata = rand_line();
    end
    if (mem_req_valid) begin
      if (rdy_wait < 0) rdy_wait = (rdy_delay_cfg < 0) ? $urandom_range(0, 3) : rdy_delay_cfg;
      if (rdy_wait == 0) begin
        mem_req_ready = 1;
        rdy_wait = -1;
        mem_out = 1;
        resp_cnt = (resp_delay_cfg < 0) ? $urandom_range(0, 3) : resp_delay_cfg;
      end else begin
        rdy_wait--;
      end
    end else if (spur) begin
      mem_req_ready = $urandom_range(0, 1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare();
    observe();
    drive_req();
    drive_mem();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ic_gnt"}, ic_gnt, 0);
    check({tag, "_dc_gnt"}, dc_gnt, 0);
    check({tag, "_ic_resp_valid"}, ic_resp_valid, 0);
    check({tag, "_dc_resp_valid"}, dc_resp_valid, 0);
    check({tag, "_ic_rdata"}, ic_rdata, 0);
    check({tag, "_dc_rdata"}, dc_rdata, 0);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it on a later falling edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1;
    ic_req = 0; dc_req = 0; dc_we = 0; ic_mode = 0; dc_mode = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_out = 0; rdy_wait = -1;
    model_reset();
    #1;
    check_outputs_zero(tag);
    repeat (2) cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    ic_mode = 0; dc_mode = 0; rdy_delay_cfg = 0; resp_delay_cfg = 0; rdy_wait = -1; resp_cnt = 0;
    spur = 0; mem_out = 0; resp_data_rand = 0; resp_data_cfg = '0;
    model_reset();
    clear_obs();
    #23;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 0;

    // Single I-cache fill from an unaligned address.
    clear_obs();
    ic_req = 1; ic_addr = 32'h0000_1004; ic_mode = 1;
    rdy_delay_cfg = 1; resp_delay_cfg = 1; resp_data_rand = 0; resp_data_cfg = {16{8'hAA}};
    repeat (12) cycle();
    check("t1_ic_gnt_count", n_ic_gnt, 1);
    check("t1_mem_addr", obs_addr, 32'h0000_1000);
    check("t1_mem_we", obs_we, 0);
    check("t1_ic_resp_count", n_ic_rv, 1);
    check("t1_ic_rdata", ic_rdata, {16{8'hAA}});
    check("t1_dc_quiet", n_dc_nonzero, 0);

    // Simultaneous requests after reset: D-cache first, then I-cache.
    do_reset("t2rst");
    clear_obs();
    ic_req = 1; ic_addr = 32'h0000_0100; ic_mode = 1;
    dc_req = 1; dc_addr = 32'h0000_0200; dc_we = 0; dc_mode = 1;
    rdy_delay_cfg = 0; resp_delay_cfg = 0;
    repeat (14) cycle();
    check("t2_grant_count", gnt_order.size(), 2);
    if (gnt_order.size() == 2) begin
      check("t2_first_grant_dc", gnt_order[0], 1);
      check("t2_second_grant_ic", gnt_order[1], 0);
    end
    check("t2_no_double_grant", n_both_gnt, 0);

    // D-cache writeback with memory stalling ready for five cycles.
    clear_obs();
    dc_req = 1; dc_we = 1; dc_addr = 32'h0000_2010; dc_mode = 1;
    dc_wdata = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    rdy_delay_cfg = 5; resp_delay_cfg = 1; resp_data_rand = 1;
    repeat (14) cycle();
    check("t3_valid_cycles", n_valid, 6);
    check("t3_stable", n_unstable, 0);
    check("t3_mem_addr", obs_addr, 32'h0000_2010);
    check("t3_mem_we", obs_we, 1);
    check("t3_mem_wdata", obs_wdata, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
    check("t3_dc_resp_count", n_dc_rv, 1);
    check("t3_dc_rdata_ack", dc_rdata, 0);

    // Both requesters held continuously: grants alternate starting with D-cache.
    do_reset("t4rst");
    clear_obs();
    rdy_delay_cfg = 0; resp_delay_cfg = 0; resp_data_rand = 1;
    ic_req = 1; ic_addr = $urandom; ic_mode = 2;
    dc_req = 1; dc_addr = $urandom; dc_we = 0; dc_wdata = rand_line(); dc_mode = 2;
    for (int i = 0; i < 80 && gnt_order.size() < 6; i++) cycle();
    check("t4_grant_count", gnt_order.size(), 6);
    for (int i = 0; i < 6 && i < gnt_order.size(); i++) check("t4_grant_order", gnt_order[i], (i % 2 == 0) ? 1 : 0);
    check("t4_grant_overlaps_resp", n_rv_with_gnt > 0, 1);
    ic_mode = 1; dc_mode = 1;
    repeat (25) cycle();
    ic_req = 0; dc_req = 0; ic_mode = 0; dc_mode = 0;
    repeat (15) cycle();

    // Reset while waiting for the memory response; the late response must be ignored.
    clear_obs();
    ic_req = 1; ic_addr = 32'h0000_3000; ic_mode = 1;
    rdy_delay_cfg = 0; resp_delay_cfg = 8;
    repeat (4) cycle();
    check("t5_in_flight", n_ic_gnt, 1);
    do_reset("t5rst");
    clear_obs();
    mem_resp_valid = 1; mem_rdata = rand_line();
    repeat (4) cycle();
    check("t5_stray_ignored", n_ic_rv + n_dc_rv, 0);
    check("t5_ic_rdata", ic_rdata, 0);
    dc_req = 1; dc_addr = 32'h0000_4008; dc_we = 0; dc_mode = 1;
    rdy_delay_cfg = 1; resp_delay_cfg = 0; resp_data_rand = 0; resp_data_cfg = {16{8'h55}};
    repeat (12) cycle();
    check("t5_dc_gnt", n_dc_gnt, 1);
    check("t5_mem_addr", obs_addr, 32'h0000_4000);
    check("t5_dc_resp", n_dc_rv, 1);
    check("t5_dc_rdata", dc_rdata, {16{8'h55}});

    // Spurious ready/response with no requesters.
    clear_obs();
    spur = 1;
    repeat (25) cycle();
    check("t6_no_grant", n_ic_gnt + n_dc_gnt, 0);
    check("t6_no_resp", n_ic_rv + n_dc_rv, 0);
    check("t6_no_mem_req", n_valid, 0);

    // Randomized traffic with random memory timing and stray memory signals.
    clear_obs();
    rdy_delay_cfg = -1; resp_delay_cfg = -1; resp_data_rand = 1;
    ic_mode = 3; dc_mode = 3;
    repeat (3000) cycle();
    check("t7_no_double_grant", n_both_gnt, 0);
    check("t7_traffic_seen", (n_ic_rv > 10) && (n_dc_rv > 10), 1);
    ic_mode = 1; dc_mode = 1; spur = 0;
    repeat (40) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
